// File: rtl/switch_io_port_if.sv
// Processor load/store bus as seen by a memory-mapped peripheral.
// The master drives the address, write data and store strobe. The slave returns a combinational hit and read data.
interface switch_io_port_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, output wdata, output mem_write, input rdata, input hit);
  modport slave  (input addr, input wdata, input mem_write, output rdata, output hit);
endinterface

// File: rtl/switch_io_port.sv
// Switch input port: synchronise, debounce, expose as read-only registers plus a sticky change status.
// Reads are combinational with zero latency; a switch change reaches deb DEBOUNCE_CYCLES+3 edges after first sample; no backpressure.
module switch_io_port #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          switches_num1,
  input  logic [3:0]          switches_num2,
  input  logic [1:0]          switches_op,
  switch_io_port_if.slave     bus,
  output logic                changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       r_s1, r_s2, r_cand, r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_changed;
  logic [7:0]       r_chg_cnt;

  logic [9:0]  w_raw;
  logic [31:0] w_off;
  logic        w_hit;
  logic        w_stable;
  logic        w_commit;
  logic        w_wr_status;
  logic        w_changed_nxt;
  logic [7:0]  w_chg_base;
  logic [7:0]  w_chg_cnt_nxt;
  logic        w_unused;

  assign w_raw = {switches_op, switches_num2, switches_num1};

  // Offset compare works for any word-aligned base, not only 16-byte aligned ones.
  assign w_off = bus.addr - BASE_ADDR;
  assign w_hit = (w_off[31:4] == 28'd0) && (w_off[1:0] == 2'b00);

  assign w_stable    = (r_cnt == CNT_MAX) && (r_deb == r_cand);
  assign w_commit    = (r_s2 == r_cand) && (r_cnt == CNT_MAX) && (r_deb != r_cand);
  assign w_wr_status = bus.mem_write && w_hit && (w_off[3:2] == 2'd3);

  // A commit overrides a same-cycle clear on each field independently.
  always_comb begin
    w_changed_nxt = r_changed;
    if (w_wr_status && bus.wdata[0]) w_changed_nxt = 1'b0;
    if (w_commit)                    w_changed_nxt = 1'b1;
    w_chg_base    = (w_wr_status && bus.wdata[1]) ? 8'd0 : r_chg_cnt;
    w_chg_cnt_nxt = w_commit ? (w_chg_base + 8'd1) : w_chg_base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_cand    <= '0;
      r_deb     <= '0;
      r_cnt     <= CNT_MAX;
      r_changed <= 1'b0;
      r_chg_cnt <= 8'd0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_MAX) begin
        if (r_deb != r_cand) r_deb <= r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_changed <= w_changed_nxt;
      r_chg_cnt <= w_chg_cnt_nxt;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (w_hit) begin
      case (w_off[3:2])
        2'd0:    bus.rdata = {28'd0, r_deb[3:0]};
        2'd1:    bus.rdata = {28'd0, r_deb[7:4]};
        2'd2:    bus.rdata = {30'd0, r_deb[9:8]};
        default: bus.rdata = {16'd0, r_chg_cnt, 6'd0, w_stable, r_changed};
      endcase
    end
  end

  assign bus.hit  = w_hit;
  assign changed  = r_changed;
  assign w_unused = ^bus.wdata[31:2];

endmodule

// File: tb/tb_switch_io_port.sv
module tb_switch_io_port;

  logic       clk;
  logic       reset;
  logic [3:0] switches_num1;
  logic [3:0] switches_num2;
  logic [1:0] switches_op;
  logic       changed;

  int n_vec = 0;
  int n_err = 0;

  switch_io_port_if bus ();

  switch_io_port #(
    .BASE_ADDR      (32'h0000_0100),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .switches_num1(switches_num1),
    .switches_num2(switches_num2),
    .switches_op  (switches_op),
    .bus          (bus),
    .changed      (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic exp_hit);
    bus.addr = a;
    #1;
    check({tag, "_rdata"}, bus.rdata, exp_d);
    check({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_write = 1'b1;
    tick();
    bus.mem_write = 1'b0;
    bus.wdata     = 32'd0;
  endtask

  initial begin
    reset         = 1'b0;
    switches_num1 = 4'h0;
    switches_num2 = 4'h0;
    switches_op   = 2'b00;
    bus.addr      = 32'h10C;
    bus.wdata     = 32'd0;
    bus.mem_write = 1'b0;

    // Reset state
    #12;
    rd("rst_status", 32'h10C, 32'h0000_0002, 1'b1);
    check("rst_changed", {31'd0, changed}, 32'd0);
    reset = 1'b1;
    tick();
    rd("idle_num1", 32'h100, 32'd0, 1'b1);
    rd("idle_num2", 32'h104, 32'd0, 1'b1);
    rd("idle_op",   32'h108, 32'd0, 1'b1);
    rd("idle_status", 32'h10C, 32'h0000_0002, 1'b1);

    // NUM1 commit exactly after edge 7
    switches_num1 = 4'hA;
    for (int i = 1; i <= 6; i++) begin
      tick();
      rd($sformatf("num1_early_e%0d", i), 32'h100, 32'd0, 1'b1);
    end
    tick();
    rd("num1_commit", 32'h100, 32'h0000_000A, 1'b1);
    rd("num1_status", 32'h10C, 32'h0000_0103, 1'b1);
    check("num1_changed", {31'd0, changed}, 32'd1);

    // 3-cycle glitch on NUM2 is rejected
    switches_num2 = 4'h5;
    tick(); tick(); tick();
    switches_num2 = 4'h0;
    tick();
    rd("glitch_unstable", 32'h10C, 32'h0000_0101, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    rd("glitch_num2", 32'h104, 32'd0, 1'b1);
    rd("glitch_status", 32'h10C, 32'h0000_0103, 1'b1);

    // STATUS clears and ignored writes
    store(32'h10C, 32'h1);
    rd("clr_changed", 32'h10C, 32'h0000_0102, 1'b1);
    check("clr_changed_pin", {31'd0, changed}, 32'd0);
    store(32'h10C, 32'h2);
    rd("clr_cnt", 32'h10C, 32'h0000_0002, 1'b1);
    store(32'h100, 32'hFFFF);
    rd("ro_num1", 32'h100, 32'h0000_000A, 1'b1);
    rd("ro_status", 32'h10C, 32'h0000_0002, 1'b1);

    // Commit of OP on the same edge as a full STATUS clear
    switches_op = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    rd("op_early", 32'h108, 32'd0, 1'b1);
    store(32'h10C, 32'h3);
    rd("race_status", 32'h10C, 32'h0000_0103, 1'b1);
    rd("race_op", 32'h108, 32'h0000_0003, 1'b1);
    check("race_changed", {31'd0, changed}, 32'd1);

    // 256 commits wrap chg_cnt
    store(32'h10C, 32'h2);
    rd("wrap_start", 32'h10C, 32'h0000_0003, 1'b1);
    for (int i = 0; i < 256; i++) begin
      switches_num1 = i[0] ? 4'hA : 4'h5;
      for (int j = 0; j < 8; j++) tick();
      if (i == 254) rd("wrap_ff", 32'h10C, 32'h0000_FF03, 1'b1);
    end
    rd("wrap_00", 32'h10C, 32'h0000_0003, 1'b1);
    rd("wrap_num1", 32'h100, 32'h0000_000A, 1'b1);

    // Out-of-window and misaligned addresses
    rd("miss_110", 32'h110, 32'd0, 1'b0);
    rd("miss_102", 32'h102, 32'd0, 1'b0);
    rd("miss_0fc", 32'h0FC, 32'd0, 1'b0);

    // Asynchronous reset mid-debounce
    switches_num1 = 4'h3;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("arst_changed", {31'd0, changed}, 32'd0);
    rd("arst_status", 32'h10C, 32'h0000_0002, 1'b1);
    rd("arst_num1", 32'h100, 32'd0, 1'b1);
    rd("arst_op", 32'h108, 32'd0, 1'b1);
    reset = 1'b1;

    // Non-zero switches at release commit with normal latency
    for (int i = 0; i < 6; i++) tick();
    rd("post_early", 32'h100, 32'd0, 1'b1);
    tick();
    rd("post_num1", 32'h100, 32'h0000_0003, 1'b1);
    rd("post_op", 32'h108, 32'h0000_0003, 1'b1);
    rd("post_status", 32'h10C, 32'h0000_0103, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
